serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes diff = a - b - borrow_in, LSB first, one bit per clock.
- One combinational full-subtractor cell plus a registered borrow flip-flop.
- Sits beside the structural adders in the arithmetic library as the subtract direction.
- Operands enter through a valid/ready handshake; the result leaves through a valid/ready handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- borrow_in  in  1  initial borrow.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  a - b - borrow_in, modulo 2^WIDTH.
- borrow_out  out  1  final borrow (1 when the unsigned result is negative).
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Reset: clk and rst_n are already decided as one clock with synchronous active-low reset. rst_n=0 at a clk edge forces:
  - state to IDLE, in_ready=1, out_valid=0;
  - diff, borrow_out and ovf to 0;
  - the counter, shift registers and borrow flip-flop to 0.
- Reset mid-operation (BUSY or DONE) abandons the operation. No partial result is ever presented.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready at edge E0: load a_sr<=a, b_sr<=b, brw<=borrow_in, cnt<=0; go to BUSY.
- State BUSY: in_ready=0, out_valid=0. At each edge:
  - d = a_sr[0] ^ b_sr[0] ^ brw.
  - brw <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw).
  - Shift a_sr and b_sr right by one.
  - Shift d into the MSB of the diff shift register.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 at the edge, go to DONE.
- State DONE:
  - out_valid=1. diff, borrow_out and ovf are stable and held.
  - ovf = (a_msb != b_msb) & (diff[WIDTH-1] != a_msb). a_msb is captured at E0.
  - On out_valid & out_ready, go to IDLE at that edge.
  - out_ready=0 holds DONE indefinitely with all outputs unchanged.
- Latency:
  - out_valid first rises at edge E0+WIDTH.
  - The minimum accept-to-accept period is WIDTH+2 cycles: IDLE is revisited for at least one cycle after the result handshake.
  - There is no overlap of operations.
- in_valid during BUSY/DONE is ignored. Operand inputs are sampled only at the accept edge.
- diff/borrow_out/ovf values outside DONE: they retain the last result (0 after reset). The bench must not check them unless out_valid=1.
- Arithmetic: all bits are unsigned modulo 2^WIDTH. Wrap-around is silent and is flagged only via borrow_out/ovf.

Decomposition:
- Shared package arith_pkg:
  - state typedef {IDLE, BUSY, DONE}, 2-bit encoding;
  - DEFAULT_WIDTH=8.
- Sub-module full_subtractor:
  - inputs a, b, borrow_in; outputs diff, borrow_out;
  - purely combinational;
  - instantiated once inside serial_subtractor.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, borrow_in=0 -> out_valid at E0+8, diff=0x02, borrow_out=0, ovf=0.
- a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1, ovf=0.
- a=0x80, b=0x01, borrow_in=0 -> diff=0x7F, borrow_out=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, ovf=1.
- a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1, ovf=0.
- Hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands applied -> outputs unchanged and in_ready=0 throughout. Then out_ready=1 -> IDLE, and the next operands are accepted one cycle later.
- Drive rst_n=0 for one edge at cnt=3 of a=0xAA, b=0x55 -> state IDLE, out_valid=0, diff=0, in_ready=1 on the next cycle. A subsequent 0xAA-0x55 yields diff=0x55, borrow_out=0, ovf=1.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types and defaults for the arithmetic library.
package arith_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   // Serial operator sequencing: idle, shifting bits, result held.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - borrow_in.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic borrow_in,
   output logic diff,
   output logic borrow_out
);

   // Difference bit and borrow generation for a single bit position.
   always_comb begin
      diff       = a ^ b ^ borrow_in;
      borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
   end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock, valid/ready on both sides.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t             state;
   state_t             state_nxt;
   logic               accept_c;
   logic               last_c;

   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-1:0]   diff_sr;
   logic [CNT_W-1:0]   cnt;
   logic               brw;
   logic               a_msb;
   logic               b_msb;
   logic               d_bit;
   logic               brw_nxt;

   full_subtractor u_fs (
      .a          (a_sr[0]),
      .b          (b_sr[0]),
      .borrow_in  (brw),
      .diff       (d_bit),
      .borrow_out (brw_nxt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode plus accept/last-bit strobes for the datapath.
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      last_c    = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept_c  = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
               last_c    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_valid && out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake flags track the upcoming state so they stay registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
      end
   end

   // Operand shifting, borrow chain and result capture on the final bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr       <= '0;
         b_sr       <= '0;
         diff_sr    <= '0;
         cnt        <= '0;
         brw        <= 1'b0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         ovf        <= 1'b0;
      end else if (accept_c) begin
         a_sr  <= a;
         b_sr  <= b;
         brw   <= borrow_in;
         cnt   <= '0;
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (state == BUSY) begin
         a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
         diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
         brw     <= brw_nxt;
         cnt     <= cnt + CNT_W'(1);
         if (last_c) begin
            diff       <= {d_bit, diff_sr[WIDTH-1:1]};
            borrow_out <= brw_nxt;
            ovf        <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
         end
      end
   end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         borrow_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         ovf;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow_out (borrow_out),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present operands and wait (bounded) for the accept edge; returns cycles waited.
   task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                         output int waited);
      waited    = 0;
      a         = av;
      b         = bv;
      borrow_in = bi;
      in_valid  = 1'b1;
      while (!in_ready && waited < 50) begin
         step();
         waited++;
      end
      if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   // Called just after the accept edge: checks latency WIDTH and the result.
   task automatic wait_done(input string tag, input logic [W-1:0] ed, input logic ebo,
                            input logic eov);
      for (int i = 0; i < int'(W) - 1; i++) step();
      check({tag, "_busy_valid"}, 32'(out_valid), 32'd0);
      step();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_diff"}, 32'(diff), 32'(ed));
      check({tag, "_borrow"}, 32'(borrow_out), 32'(ebo));
      check({tag, "_ovf"}, 32'(ovf), 32'(eov));
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic bi, input logic [W-1:0] ed, input logic ebo,
                         input logic eov);
      int waited;
      accept(av, bv, bi, waited);
      wait_done(tag, ed, ebo, eov);
      release_result(tag);
   endtask

   // Directed sequence.
   initial begin
      int waited;
      logic [W-1:0] junk_a [5] = '{8'h11, 8'h22, 8'hF0, 8'h00, 8'hFF};
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      borrow_in = 1'b0;
      step();
      step();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_borrow", 32'(borrow_out), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      step();

      run_op("5m3",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      run_op("3m5",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
      run_op("80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op("7Fm FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
      run_op("0m0b1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

      // Hold DONE with out_ready low while new operands are waved at the input.
      accept(8'h12, 8'h34, 1'b0, waited);
      wait_done("hold", 8'hDE, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid  = 1'b1;
         a         = junk_a[i];
         b         = ~junk_a[i];
         borrow_in = 1'b1;
         step();
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_diff", 32'(diff), 32'h0DE);
         check("hold_borrow", 32'(borrow_out), 32'd1);
         check("hold_ovf", 32'(ovf), 32'd0);
      end
      a         = 8'h05;
      b         = 8'h03;
      borrow_in = 1'b0;
      release_result("hold");
      accept(8'h05, 8'h03, 1'b0, waited);
      check("hold_next_wait", 32'(waited), 32'd0);
      check("hold_next_busy", 32'(in_ready), 32'd0);
      wait_done("after_hold", 8'h02, 1'b0, 1'b0);
      release_result("after_hold");

      // Reset in the middle of a shift.
      accept(8'hAA, 8'h55, 1'b0, waited);
      step();
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_diff", 32'(diff), 32'd0);
      step();
      check("midrst_still_idle", 32'(out_valid), 32'd0);
      run_op("AAm55", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_serial_subtractor
